kbd_mmio_ctrl: RTL and testbench

Bus-side controller between the multi-cycle processor datapath and the data Memory. It decodes the processor address and passes RAM accesses through to Memory unchanged. It captures keyboard codes on rising edges of the asynchronous `sample` strobe into an 8-entry FIFO. The FIFO and a status word are exposed at two memory-mapped addresses at the top of the data space, and a read of the data address pops one entry.

---
 rtl/kbd_mmio_ctrl_if.sv | 23 ++
 rtl/kbd_mmio_ctrl.sv | 101 ++++++++++
 tb/tb_kbd_mmio_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_mmio_ctrl_if.sv
// Processor-side data bus plus the Memory port, as seen by the keyboard MMIO controller.
// The master side is the processor and the Memory together; the controller sits between them.
interface kbd_mmio_ctrl_if;
  logic [31:0] addr;
  logic        MemWrite;
  logic [31:0] WD;
  logic        rd_strobe;
  logic [31:0] RD;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport master (
    output addr, MemWrite, WD, rd_strobe, mem_rd,
    input  RD, mem_addr, mem_we, mem_wd
  );

  modport slave (
    input  addr, MemWrite, WD, rd_strobe, mem_rd,
    output RD, mem_addr, mem_we, mem_wd
  );
endinterface

// File: rtl/kbd_mmio_ctrl.sv
// Address decode and RAM pass-through, with an 8-entry keyboard FIFO and status word
// mapped at the top two data addresses. Keyboard codes arrive on rising edges of 'sample'.
module kbd_mmio_ctrl #(
  parameter logic [31:0] KBD_DATA_ADDR = 32'd16383,
  parameter logic [31:0] KBD_STAT_ADDR = 32'd16382,
  parameter int          FIFO_DEPTH    = 8,
  parameter int          PTR_W         = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  kbd_mmio_ctrl_if.slave       bus,
  input  logic                 sample,
  input  logic [7:0]           key_reg,
  output logic                 kbd_irq,
  output logic                 kbd_ovf
);

  localparam int CNT_W = PTR_W + 1;

  logic             s1_q, s2_q, s3_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       fifo_q [FIFO_DEPTH];

  logic is_data, is_stat, is_mmio;
  logic empty, full;
  logic push_req, pop, do_push, ovf_set, ovf_clr;
  logic [3:0] count_4;

  assign is_data = (bus.addr == KBD_DATA_ADDR);
  assign is_stat = (bus.addr == KBD_STAT_ADDR);
  assign is_mmio = is_data | is_stat;

  assign bus.mem_addr = bus.addr;
  assign bus.mem_wd   = bus.WD;
  assign bus.mem_we   = bus.MemWrite & ~is_mmio;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign push_req = s2_q & ~s3_q;
  assign pop      = bus.rd_strobe & is_data & ~empty;
  // A full FIFO still accepts a code when an entry leaves on the same edge.
  assign do_push  = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;
  assign ovf_clr  = bus.MemWrite & is_stat & bus.WD[2];
  assign count_4  = 4'(count_q);

  assign kbd_irq = ~empty;
  assign kbd_ovf = ovf_q;

  always_comb begin
    bus.RD = bus.mem_rd;
    if (is_data) begin
      bus.RD = empty ? 32'b0 : {24'b0, fifo_q[rd_ptr_q]};
    end else if (is_stat) begin
      bus.RD = {20'b0, count_4, 5'b0, ovf_q, full, ~empty};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(pop);
    ovf_d    = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Synchronizer flops reset high so a strobe idling high never looks like a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      s3_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      s1_q     <= sample;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_q[wr_ptr_q] <= key_reg;
    end
  end

endmodule

// File: tb/tb_kbd_mmio_ctrl.sv
// Directed and randomized bench for kbd_mmio_ctrl against a queue-based model of the
// keyboard FIFO, overflow flag and a small RAM behind the pass-through port.
module tb_kbd_mmio_ctrl;
  localparam logic [31:0] KD = 32'd16383;
  localparam logic [31:0] KS = 32'd16382;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample;
  logic [7:0] key_reg;
  logic       kbd_irq;
  logic       kbd_ovf;

  kbd_mmio_ctrl_if bus ();

  kbd_mmio_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .sample  (sample),
    .key_reg (key_reg),
    .kbd_irq (kbd_irq),
    .kbd_ovf (kbd_ovf)
  );

  always #5 clk = ~clk;

  // Behavioural RAM behind the pass-through port.
  logic [31:0] ram [256];
  assign bus.mem_rd = ram[bus.mem_addr[7:0]];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wd;
  end

  // Reference model: the FIFO is just a byte queue plus a sticky overflow bit.
  logic [7:0] exp_q[$];
  bit         exp_ovf;
  int         n_pass = 0;
  int         n_fail = 0;
  int         n_total = 0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_head();
    return (exp_q.size() != 0) ? {24'b0, exp_q[0]} : 32'b0;
  endfunction

  function automatic logic [31:0] exp_status();
    int n;
    n = exp_q.size();
    return {20'b0, 4'(n), 5'b0, exp_ovf, (n == 8), (n != 0)};
  endfunction

  task automatic check_status(input string tag);
    bus.addr = KS; bus.MemWrite = 1'b0; bus.rd_strobe = 1'b0;
    #1;
    chk({tag, "_stat"}, bus.RD, exp_status());
    chk({tag, "_irq"}, {31'b0, kbd_irq}, {31'b0, exp_q.size() != 0});
    chk({tag, "_ovf"}, {31'b0, kbd_ovf}, {31'b0, exp_ovf});
  endtask

  task automatic pop_one(input string tag);
    bus.addr = KD; bus.MemWrite = 1'b0; bus.rd_strobe = 1'b1;
    #1;
    chk(tag, bus.RD, exp_head());
    tick();
    bus.rd_strobe = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  // One keyboard code: low for 3 clocks, then a rise; the push lands on the 3rd edge after it.
  task automatic press(input logic [7:0] key, input bit with_pop);
    bit was_full, popped;
    sample = 1'b0; key_reg = key;
    repeat (3) tick();
    sample = 1'b1;
    tick();
    tick();
    bus.addr = KD; bus.MemWrite = 1'b0; bus.rd_strobe = with_pop;
    #1;
    chk("head_at_push", bus.RD, exp_head());
    tick();
    bus.rd_strobe = 1'b0;
    was_full = (exp_q.size() == 8);
    popped   = with_pop && (exp_q.size() != 0);
    if (popped) void'(exp_q.pop_front());
    if (!was_full || popped) exp_q.push_back(key);
    else exp_ovf = 1'b1;
  endtask

  task automatic write_stat(input logic [31:0] wd);
    bus.addr = KS; bus.WD = wd; bus.MemWrite = 1'b1; bus.rd_strobe = 1'b0;
    #1;
    chk("stat_wr_mem_we", {31'b0, bus.mem_we}, 32'b0);
    tick();
    bus.MemWrite = 1'b0;
    if (wd[2]) exp_ovf = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rv;
    for (int i = 0; i < 256; i++) ram[i] = 32'b0;
    rst = 1'b1; sample = 1'b1; key_reg = 8'h00;
    bus.addr = 32'b0; bus.WD = 32'b0; bus.MemWrite = 1'b0; bus.rd_strobe = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clk);
    check_status("in_reset");
    tick();
    rst = 1'b0;
    repeat (5) tick();

    // 1: idle-high strobe gives no push; RAM pass-through
    check_status("idle_after_reset");
    bus.addr = 32'h1234; bus.WD = 32'hA5A5_A5A5; bus.MemWrite = 1'b1;
    #1;
    chk("ram_wr_we", {31'b0, bus.mem_we}, 32'd1);
    chk("ram_wr_addr", bus.mem_addr, 32'h1234);
    chk("ram_wr_wd", bus.mem_wd, 32'hA5A5_A5A5);
    tick();
    bus.MemWrite = 1'b0;
    #1;
    chk("ram_rd_we", {31'b0, bus.mem_we}, 32'd0);
    chk("ram_rd", bus.RD, 32'hA5A5_A5A5);

    // 2: single code, pop, pop while empty
    press(8'd50, 1'b0);
    check_status("one_code");
    pop_one("pop_50");
    check_status("after_pop");
    pop_one("pop_empty");
    check_status("after_empty_pop");

    // 3: fill, overflow, drain in order
    for (int k = 51; k <= 58; k++) press(8'(k), 1'b0);
    check_status("full");
    press(8'd59, 1'b0);
    check_status("overflow");
    for (int k = 0; k < 9; k++) pop_one("drain");
    check_status("drained");

    // 5a: clear overflow
    write_stat(32'd4);
    check_status("ovf_cleared");

    // 4: full with coincident pop and push
    for (int k = 61; k <= 68; k++) press(8'(k), 1'b0);
    press(8'd60, 1'b1);
    check_status("full_pop_push");
    for (int k = 0; k < 8; k++) pop_one("drain_60");
    check_status("drained_60");

    // 5b: write to data address is ignored
    press(8'h3C, 1'b0);
    bus.addr = KD; bus.WD = 32'hFF; bus.MemWrite = 1'b1;
    #1;
    chk("data_wr_mem_we", {31'b0, bus.mem_we}, 32'b0);
    tick();
    bus.MemWrite = 1'b0;
    check_status("data_wr_ignored");

    // Randomized mix of codes, pops, stray strobes and status writes
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0, 1: press(8'($urandom_range(0, 255)), 1'b0);
        2:    press(8'($urandom_range(0, 255)), 1'b1);
        3:    pop_one("rand_pop");
        4:    write_stat($urandom_range(0, 7));
        default: begin
          ra = 32'($urandom_range(0, 255));
          rv = $urandom;
          bus.addr = ra; bus.WD = rv; bus.MemWrite = 1'b1;
          tick();
          bus.MemWrite = 1'b0; bus.rd_strobe = 1'b1;
          #1;
          chk("rand_ram_rd", bus.RD, rv);
          tick();
          bus.rd_strobe = 1'b0;
        end
      endcase
      check_status("rand");
    end
    while (exp_q.size() != 0) pop_one("rand_drain");
    write_stat(32'd4);

    // 6: reset in the middle of a sequence
    press(8'd71, 1'b0);
    press(8'd72, 1'b0);
    sample = 1'b0; key_reg = 8'd73;
    repeat (3) tick();
    sample = 1'b1;
    tick();
    rst = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    check_status("mid_reset");
    sample = 1'b0;
    tick();
    sample = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check_status("post_reset_idle");
    press(8'd74, 1'b0);
    check_status("post_reset_one");
    pop_one("post_reset_pop");
    check_status("post_reset_empty");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
